// File: rtl/ws2812_tx_if.sv
// rtl/ws2812_tx_if.sv - start/status handshake, colour buffer read port and strip data pin
interface ws2812_tx_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [7:0]  rd_addr;
  logic [23:0] rd_data;
  logic        dout;

  // Frame requester / colour buffer side
  modport master (
    output start,
    output rd_data,
    input  busy,
    input  done,
    input  rd_addr,
    input  dout
  );

  // Transmitter side
  modport slave (
    input  start,
    input  rd_data,
    output busy,
    output done,
    output rd_addr,
    output dout
  );
endinterface

// File: rtl/ws2812_tx.sv
// rtl/ws2812_tx.sv - WS2812 one-wire NRZ frame transmitter fed from the averaged colour buffer
module ws2812_tx #(
  parameter int NUM_LEDS = 20,
  parameter int T0H      = 40,
  parameter int T1H      = 80,
  parameter int T_BIT    = 125,
  parameter int T_RST    = 8000
) (
  input logic     clk,
  input logic     rst_n,
  ws2812_tx_if.slave bus
);

  // One timer serves both the bit cell and the latch period, so size it for the longer
  localparam int TMAX = (T_BIT > T_RST) ? T_BIT : T_RST;
  localparam int TW   = (TMAX > 2) ? $clog2(TMAX) : 2;

  localparam logic [TW-1:0] BIT_LAST = TW'(T_BIT - 1);
  localparam logic [TW-1:0] RST_LAST = TW'(T_RST - 1);
  localparam logic [TW-1:0] RST_PRE  = TW'((T_RST > 1) ? (T_RST - 2) : 0);
  localparam logic [TW-1:0] TH0      = TW'(T0H);
  localparam logic [TW-1:0] TH1      = TW'(T1H);
  localparam logic [TW-1:0] CAP_TICK = TW'(2);
  localparam logic [7:0]    LAST_LED = 8'(NUM_LEDS - 1);
  localparam logic          RST_ONE  = (T_RST == 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, LATCH} state_t;

  state_t        state;
  logic [23:0]   shift_reg;
  logic [23:0]   hold_reg;
  logic [7:0]    led_cnt;
  logic [4:0]    bit_cnt;
  logic [TW-1:0] bit_timer;

  logic          cell_end;
  logic          last_bit;
  logic          frame_end;
  logic [TW-1:0] next_timer;
  logic          next_msb;
  logic          next_high;

  // Buffer holds {R,G,B}; the strip wants G first, then R, then B
  function automatic logic [23:0] reorder(input logic [23:0] w);
    return {w[15:8], w[23:16], w[7:0]};
  endfunction

  // Look one cycle ahead so dout can be registered without adding a cycle of skew
  assign cell_end   = (bit_timer == BIT_LAST);
  assign last_bit   = (bit_cnt == 5'd23);
  assign frame_end  = cell_end && last_bit && (led_cnt == LAST_LED);
  assign next_timer = cell_end ? '0 : bit_timer + 1'b1;
  assign next_msb   = !cell_end ? shift_reg[23] : (last_bit ? hold_reg[23] : shift_reg[22]);
  assign next_high  = next_timer < (next_msb ? TH1 : TH0);

  // Frame sequencer: fetch, serialise with next-LED prefetch, then latch low
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      hold_reg    <= '0;
      led_cnt     <= '0;
      bit_cnt     <= '0;
      bit_timer   <= '0;
      bus.dout    <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rd_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.dout    <= 1'b0;
          bus.done    <= 1'b0;
          bus.rd_addr <= '0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            state    <= FETCH;
          end else begin
            bus.busy <= 1'b0;
          end
        end

        FETCH: begin
          state <= LOAD;
        end

        LOAD: begin
          shift_reg <= reorder(bus.rd_data);
          led_cnt   <= '0;
          bit_cnt   <= '0;
          bit_timer <= '0;
          // Every cell opens high because T0H is at least one cycle
          bus.dout  <= 1'b1;
          state     <= SHIFT;
        end

        SHIFT: begin
          // Address goes out in cycle 0 of bit 0, data returns two cycles later
          if (bit_cnt == 5'd0 && bit_timer == '0 && led_cnt != LAST_LED) begin
            bus.rd_addr <= led_cnt + 8'd1;
          end
          if (bit_cnt == 5'd0 && bit_timer == CAP_TICK && led_cnt != LAST_LED) begin
            hold_reg <= reorder(bus.rd_data);
          end

          if (frame_end) begin
            bus.dout  <= 1'b0;
            bus.done  <= RST_ONE;
            bit_timer <= '0;
            state     <= LATCH;
          end else begin
            bus.dout  <= next_high;
            bit_timer <= next_timer;
            if (cell_end) begin
              if (last_bit) begin
                shift_reg <= hold_reg;
                bit_cnt   <= '0;
                led_cnt   <= led_cnt + 8'd1;
              end else begin
                shift_reg <= {shift_reg[22:0], 1'b0};
                bit_cnt   <= bit_cnt + 5'd1;
              end
            end
          end
        end

        LATCH: begin
          bus.dout <= 1'b0;
          if (bit_timer == RST_LAST) begin
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.rd_addr <= '0;
            bit_timer   <= '0;
            led_cnt     <= '0;
            bit_cnt     <= '0;
            state       <= IDLE;
          end else begin
            bus.done  <= (bit_timer == RST_PRE);
            bit_timer <= bit_timer + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
